cpu_core_mc: RTL and testbench
==============================

# cpu_core_mc

Parametrised multi-cycle successor to the single-cycle 8-bit computer. It has the same A/B register, ALU, status and jump architecture. It adds configurable data/address widths, an external data memory with a req/ack handshake, a HALT state and a full Z/N/C/V flag set. The top level instantiates it between the instruction ROM and the data memory/bus. It exposes the same debug buses (ALU, A, B).

## Interface
- DATA_W, 8: register, ALU, literal and memory data width.
- ADDR_W, 8: PC and data-address width; jump target = literal[ADDR_W-1:0].
- OPC_W, 7: opcode width; instruction width = OPC_W+DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  current PC.
- imem_data  in  OPC_W+DATA_W  {opcode, literal}; combinational ROM, valid same cycle.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req.
- dmem_addr  out  ADDR_W  literal or regB (per opcode).
- dmem_wdata  out  DATA_W  regA/regB or ALU result (per opcode).
- dmem_rdata  in  DATA_W  sampled on cycle dmem_ack=1.
- dmem_ack  in  1  one-cycle completion strobe.
- alu_out  out  DATA_W  combinational ALU result.
- regA_out, regB_out  out  DATA_W  register contents.
- flags_out  out  4  {Z,N,C,V}.
- halted  out  1  core in HALT.

## Operation
- States: FETCH, EXEC, MEM, HALT.
- FETCH: latch imem_data into IR.
  - Memory opcode → MEM.
  - HALT opcode → HALT.
  - Otherwise → EXEC.
- EXEC:
  - ALU op: A operand = A/B mux; B operand = B/literal/MDR mux.
  - Write A and/or B per decode; update flags if flags_write.
  - Jumps: PC = target when the condition holds on the registered flags; otherwise PC+1.
  - → FETCH.
- MEM: drive req/we/addr/wdata and hold them stable until the ack cycle.
  - Read: capture rdata into MDR → EXEC, which completes the op using MDR.
  - Write: PC+1 → FETCH.
- HALT: absorbing state. PC, registers and flags frozen; dmem_req=0; exit only by reset.
- Jump conditions: JMP always, JEQ Z, JNE !Z, JGT !Z&!N, JLT N, JGE !N, JLE Z|N, JCS C.
- Arithmetic:
  - Modulo 2^DATA_W.
  - ADD: C = carry out of the MSB.
  - SUB: C = borrow (a<b unsigned).
  - V = signed overflow.
  - Logic and shift ops: C and V cleared.
  - Z = (result==0); N = result MSB.
- PC wraps from 2^ADDR_W−1 to 0.
- Undefined opcode: NOP (PC+1, no writes).

## Timing
- Reset (async assert, sync release): state=FETCH, PC=0, A=B=MDR=IR=0, flags=0, dmem_req=0, dmem_we=0, halted=0.
- Cycles per instruction:
  - ALU/jump/NOP: 2 (FETCH, EXEC).
  - Store: 2+N, where N = cycles until ack (minimum 1).
  - Load: 3+N.
- dmem_req rises the cycle after FETCH. It falls the cycle after ack and never rises back-to-back without an intervening FETCH.
- dmem_ack outside MEM is ignored.
- rst_n low during MEM drops dmem_req immediately (async); a pending ack is discarded.
- Flags written in EXEC are visible to a jump in the next instruction.

## Configuration
- CPU_CV_FLAGS_EN:
  - Defined: C and V computed as above.
  - Undefined: C and V are constant 0. JCS is then never taken and JGT/JLE use Z/N only (unchanged).

## Structure
- Package cpu_core_pkg holds:
  - opcode localparams;
  - state enum;
  - alu_op enum;
  - jump_cond enum;
  - mux select encodings;
  - decoded control struct (alu_op, muxA/muxB sel, regA/regB load, mem_rd, mem_wr, addr_sel, wdata_sel, flags_write, jump_cond, halt).
- Sub-module alu_flags (DATA_W): a, b, op → result, c, v; Z/N are derived in the core.
- Decode is a function in the package, not a module.

## Test plan
- Assert rst_n mid-MEM with dmem_req=1 → dmem_req=0 in the same cycle; after release PC=0, A=B=0, flags=0.
- MOV A,#0x05; MOV B,#0xFB; ADD A,B (DATA_W=8) → A=0x00, Z=1, N=0, C=1, V=0; without the macro C=0.
- Store A to [0x10] with ack delayed 3 cycles → req/we/addr=0x10/wdata held for 4 cycles; PC advances only after ack; total 6 cycles.
- Load B from [0x20], rdata=0x7F → B=0x7F on the EXEC edge; SUB then JEQ is not taken when A≠B and taken when A=0x7F.
- HALT at PC=3 → halted=1 from the next edge; PC stays 3 for 20 cycles; no dmem_req.
- ADDR_W=4, NOP at PC=15 → PC=0 next; JMP #0x1A jumps to 0xA.

Source files
------------

// File: rtl/cpu_core_pkg.sv
`default_nettype none
// cpu_core_pkg -- ISA encoding, FSM/ALU/jump enums, control struct and decoder
// for cpu_core_mc. Rev 1.0
package cpu_core_pkg;

  // Opcodes compare as 32-bit values so any OPC_W up to 32 decodes; set upper
  // opcode bits make an instruction undefined, which executes as NOP.
  localparam logic [31:0] OP_NOP    = 32'h00;
  localparam logic [31:0] OP_MOVA_I = 32'h01;
  localparam logic [31:0] OP_MOVB_I = 32'h02;
  localparam logic [31:0] OP_MOVA_B = 32'h03;
  localparam logic [31:0] OP_MOVB_A = 32'h04;
  localparam logic [31:0] OP_ADD    = 32'h05;
  localparam logic [31:0] OP_SUB    = 32'h06;
  localparam logic [31:0] OP_AND    = 32'h07;
  localparam logic [31:0] OP_OR     = 32'h08;
  localparam logic [31:0] OP_XOR    = 32'h09;
  localparam logic [31:0] OP_NOT    = 32'h0A;
  localparam logic [31:0] OP_SHL    = 32'h0B;
  localparam logic [31:0] OP_SHR    = 32'h0C;
  localparam logic [31:0] OP_ADD_I  = 32'h0D;
  localparam logic [31:0] OP_SUB_I  = 32'h0E;
  localparam logic [31:0] OP_CMP    = 32'h0F;
  localparam logic [31:0] OP_JMP    = 32'h10;
  localparam logic [31:0] OP_JEQ    = 32'h11;
  localparam logic [31:0] OP_JNE    = 32'h12;
  localparam logic [31:0] OP_JGT    = 32'h13;
  localparam logic [31:0] OP_JLT    = 32'h14;
  localparam logic [31:0] OP_JGE    = 32'h15;
  localparam logic [31:0] OP_JLE    = 32'h16;
  localparam logic [31:0] OP_JCS    = 32'h17;
  localparam logic [31:0] OP_LDA    = 32'h20;
  localparam logic [31:0] OP_LDB    = 32'h21;
  localparam logic [31:0] OP_LDA_B  = 32'h22;
  localparam logic [31:0] OP_STA    = 32'h23;
  localparam logic [31:0] OP_STB    = 32'h24;
  localparam logic [31:0] OP_STA_B  = 32'h25;
  localparam logic [31:0] OP_ST_SUM = 32'h26;
  localparam logic [31:0] OP_HALT   = 32'h7F;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_PASSA = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    JC_NONE   = 4'd0,
    JC_ALWAYS = 4'd1,
    JC_EQ     = 4'd2,
    JC_NE     = 4'd3,
    JC_GT     = 4'd4,
    JC_LT     = 4'd5,
    JC_GE     = 4'd6,
    JC_LE     = 4'd7,
    JC_CS     = 4'd8
  } jump_cond_t;

  localparam logic       SEL_A_REGA = 1'b0;
  localparam logic       SEL_A_REGB = 1'b1;
  localparam logic [1:0] SEL_B_REGB = 2'd0;
  localparam logic [1:0] SEL_B_LIT  = 2'd1;
  localparam logic [1:0] SEL_B_MDR  = 2'd2;
  localparam logic       ADDR_LIT   = 1'b0;
  localparam logic       ADDR_REGB  = 1'b1;
  localparam logic [1:0] WD_REGA    = 2'd0;
  localparam logic [1:0] WD_REGB    = 2'd1;
  localparam logic [1:0] WD_ALU     = 2'd2;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       a_sel;
    logic [1:0] b_sel;
    logic       load_a;
    logic       load_b;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic [1:0] wdata_sel;
    logic       flags_write;
    jump_cond_t jump_cond;
    logic       halt;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] opc);
    ctrl_t c;
    c           = '0;
    c.alu_op    = ALU_PASSB;
    c.jump_cond = JC_NONE;
    case (opc)
      OP_MOVA_I: begin c.b_sel = SEL_B_LIT; c.load_a = 1'b1; end
      OP_MOVB_I: begin c.b_sel = SEL_B_LIT; c.load_b = 1'b1; end
      OP_MOVA_B: begin c.alu_op = ALU_PASSA; c.a_sel = SEL_A_REGB; c.load_a = 1'b1; end
      OP_MOVB_A: begin c.alu_op = ALU_PASSA; c.load_b = 1'b1; end
      OP_ADD:    begin c.alu_op = ALU_ADD; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_SUB:    begin c.alu_op = ALU_SUB; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_AND:    begin c.alu_op = ALU_AND; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_OR:     begin c.alu_op = ALU_OR;  c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_XOR:    begin c.alu_op = ALU_XOR; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_NOT:    begin c.alu_op = ALU_NOT; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_SHL:    begin c.alu_op = ALU_SHL; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_SHR:    begin c.alu_op = ALU_SHR; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_ADD_I:  begin c.alu_op = ALU_ADD; c.b_sel = SEL_B_LIT; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_SUB_I:  begin c.alu_op = ALU_SUB; c.b_sel = SEL_B_LIT; c.load_a = 1'b1; c.flags_write = 1'b1; end
      OP_CMP:    begin c.alu_op = ALU_SUB; c.flags_write = 1'b1; end
      OP_JMP:    c.jump_cond = JC_ALWAYS;
      OP_JEQ:    c.jump_cond = JC_EQ;
      OP_JNE:    c.jump_cond = JC_NE;
      OP_JGT:    c.jump_cond = JC_GT;
      OP_JLT:    c.jump_cond = JC_LT;
      OP_JGE:    c.jump_cond = JC_GE;
      OP_JLE:    c.jump_cond = JC_LE;
      OP_JCS:    c.jump_cond = JC_CS;
      // Loads finish in EXEC by passing MDR through the ALU into the target register.
      OP_LDA:    begin c.mem_rd = 1'b1; c.b_sel = SEL_B_MDR; c.load_a = 1'b1; end
      OP_LDB:    begin c.mem_rd = 1'b1; c.b_sel = SEL_B_MDR; c.load_b = 1'b1; end
      OP_LDA_B:  begin c.mem_rd = 1'b1; c.b_sel = SEL_B_MDR; c.load_a = 1'b1; c.addr_sel = ADDR_REGB; end
      OP_STA:    begin c.mem_wr = 1'b1; c.wdata_sel = WD_REGA; end
      OP_STB:    begin c.mem_wr = 1'b1; c.wdata_sel = WD_REGB; end
      OP_STA_B:  begin c.mem_wr = 1'b1; c.wdata_sel = WD_REGA; c.addr_sel = ADDR_REGB; end
      OP_ST_SUM: begin c.mem_wr = 1'b1; c.wdata_sel = WD_ALU; c.alu_op = ALU_ADD; end
      OP_HALT:   c.halt = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_core_mc_alu.sv
`default_nettype none
// alu_flags -- DATA_W-bit ALU producing result plus carry/borrow and overflow.
// C/V are live only when CPU_CV_FLAGS_EN is defined, otherwise tied low. Rev 1.0
module alu_flags
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v
);

`ifdef CPU_CV_FLAGS_EN
  localparam logic CV_EN = 1'b1;
`else
  localparam logic CV_EN = 1'b0;
`endif

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            c_raw;
  logic            v_raw;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    c_raw  = 1'b0;
    v_raw  = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        c_raw  = sum[DATA_W];
        v_raw  = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        // diff's extra bit is set exactly when a < b unsigned, i.e. a borrow.
        result = diff[DATA_W-1:0];
        c_raw  = diff[DATA_W];
        v_raw  = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOT:   result = ~a;
      ALU_SHL:   result = {a[DATA_W-2:0], 1'b0};
      ALU_SHR:   result = {1'b0, a[DATA_W-1:1]};
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign c = c_raw & CV_EN;
  assign v = v_raw & CV_EN;

endmodule
`default_nettype wire

// File: rtl/cpu_core_mc.sv
`default_nettype none
// cpu_core_mc -- multi-cycle A/B core: FETCH/EXEC/MEM/HALT, req/ack data memory,
// Z/N/C/V flags (C/V need CPU_CV_FLAGS_EN, see alu_flags). Rev 1.0
module cpu_core_mc
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [OPC_W+DATA_W-1:0] imem_data,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]       dmem_wdata,
  input  logic [DATA_W-1:0]       dmem_rdata,
  input  logic                    dmem_ack,
  output logic [DATA_W-1:0]       alu_out,
  output logic [DATA_W-1:0]       regA_out,
  output logic [DATA_W-1:0]       regB_out,
  output logic [3:0]              flags_out,
  output logic                    halted
);

  state_t                  state;
  logic [ADDR_W-1:0]       pc;
  logic [DATA_W-1:0]       reg_a;
  logic [DATA_W-1:0]       reg_b;
  logic [DATA_W-1:0]       mdr;
  logic [OPC_W+DATA_W-1:0] ir;
  logic [3:0]              flags;

  // In FETCH the decoder looks at the ROM word directly so the branch to
  // MEM/HALT/EXEC is taken on the same edge that latches IR.
  logic [OPC_W+DATA_W-1:0] word;
  logic [OPC_W-1:0]        opc;
  logic [DATA_W-1:0]       lit;
  ctrl_t                   ctrl;

  assign word = (state == S_FETCH) ? imem_data : ir;
  assign opc  = word[OPC_W+DATA_W-1:DATA_W];
  assign lit  = word[DATA_W-1:0];
  assign ctrl = decode(32'(opc));

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  assign op_a = (ctrl.a_sel == SEL_A_REGB) ? reg_b : reg_a;

  always_comb begin
    case (ctrl.b_sel)
      SEL_B_LIT: op_b = lit;
      SEL_B_MDR: op_b = mdr;
      default:   op_b = reg_b;
    endcase
  end

  alu_flags #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (ctrl.alu_op),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v)
  );

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              jump_taken;

  assign mem_addr = (ctrl.addr_sel == ADDR_REGB) ? reg_b[ADDR_W-1:0] : lit[ADDR_W-1:0];

  always_comb begin
    case (ctrl.wdata_sel)
      WD_REGB: mem_wdata = reg_b;
      WD_ALU:  mem_wdata = alu_res;
      default: mem_wdata = reg_a;
    endcase
  end

  // flags = {Z, N, C, V}
  always_comb begin
    case (ctrl.jump_cond)
      JC_ALWAYS: jump_taken = 1'b1;
      JC_EQ:     jump_taken = flags[3];
      JC_NE:     jump_taken = !flags[3];
      JC_GT:     jump_taken = !flags[3] && !flags[2];
      JC_LT:     jump_taken = flags[2];
      JC_GE:     jump_taken = !flags[2];
      JC_LE:     jump_taken = flags[3] || flags[2];
      JC_CS:     jump_taken = flags[1];
      default:   jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      mdr        <= '0;
      ir         <= '0;
      flags      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= imem_data;
          if (ctrl.halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (ctrl.mem_rd || ctrl.mem_wr) begin
            state <= S_MEM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_MEM: begin
          // First MEM cycle launches the request; ack only counts once req is up.
          if (!dmem_req) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ctrl.mem_wr;
            dmem_addr  <= mem_addr;
            dmem_wdata <= mem_wdata;
          end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (ctrl.mem_wr) begin
              pc    <= pc + ADDR_W'(1);
              state <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (ctrl.load_a) reg_a <= alu_res;
          if (ctrl.load_b) reg_b <= alu_res;
          if (ctrl.flags_write) flags <= {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
          pc    <= jump_taken ? lit[ADDR_W-1:0] : pc + ADDR_W'(1);
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign imem_addr = pc;
  assign alu_out   = alu_res;
  assign regA_out  = reg_a;
  assign regB_out  = reg_b;
  assign flags_out = flags;

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_mc.sv
`default_nettype none
// tb_cpu_core_mc -- directed programs against cpu_core_mc (default widths and
// an ADDR_W=4 instance) with hand-computed expected register/bus values.
`timescale 1ns/1ps
module tb_cpu_core_mc;
  import cpu_core_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int OPC_W  = 7;
  localparam int IW     = OPC_W + DATA_W;

`ifdef CPU_CV_FLAGS_EN
  localparam logic CV = 1'b1;
`else
  localparam logic CV = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst4_n = 1'b0;

  logic [IW-1:0] rom  [256];
  logic [IW-1:0] rom4 [16];

  logic [ADDR_W-1:0] imem_addr;
  logic [IW-1:0]     imem_data;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata = '0;
  logic              dmem_ack   = 1'b0;
  logic [DATA_W-1:0] alu_out, reg_a, reg_b;
  logic [3:0]        flags;
  logic              halted;

  logic [3:0]        imem_addr4;
  logic [IW-1:0]     imem_data4;
  logic              dmem_req4, dmem_we4;
  logic [3:0]        dmem_addr4;
  logic [DATA_W-1:0] dmem_wdata4, alu_out4, reg_a4, reg_b4;
  logic [3:0]        flags4;
  logic              halted4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign imem_data4 = rom4[imem_addr4];

  cpu_core_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_out(alu_out), .regA_out(reg_a), .regB_out(reg_b),
    .flags_out(flags), .halted(halted)
  );

  cpu_core_mc #(.DATA_W(DATA_W), .ADDR_W(4), .OPC_W(OPC_W)) u_dut4 (
    .clk(clk), .rst_n(rst4_n),
    .imem_addr(imem_addr4), .imem_data(imem_data4),
    .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_addr(dmem_addr4),
    .dmem_wdata(dmem_wdata4), .dmem_rdata(8'h00), .dmem_ack(1'b0),
    .alu_out(alu_out4), .regA_out(reg_a4), .regB_out(reg_b4),
    .flags_out(flags4), .halted(halted4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input logic [31:0] op, input logic [7:0] lit);
    return {op[OPC_W-1:0], lit};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = enc(OP_HALT, 8'h00);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic req_seen;
    clear_rom();
    foreach (rom4[i]) rom4[i] = enc(OP_HALT, 8'h00);

    // Reset state
    tick(2);
    check("rst_pc", imem_addr, 0);
    check("rst_regs", {reg_a, reg_b}, 0);
    check("rst_flags", flags, 0);
    check("rst_req_we_halt", {dmem_req, dmem_we, halted}, 0);

    // MOV A,#05; MOV B,#FB; ADD -> A=00, Z=1, C=1 only with C/V enabled
    clear_rom();
    rom[0] = enc(OP_MOVA_I, 8'h05);
    rom[1] = enc(OP_MOVB_I, 8'hFB);
    rom[2] = enc(OP_ADD,    8'h00);
    rom[3] = enc(OP_HALT,   8'h00);
    do_reset();
    dmem_ack = 1'b1;
    tick(2);
    dmem_ack = 1'b0;
    check("mova_a", reg_a, 8'h05);
    check("mova_pc", imem_addr, 1);
    tick(2);
    check("movb_b", reg_b, 8'hFB);
    tick(2);
    check("add_a", reg_a, 8'h00);
    check("add_flags", flags, {1'b1, 1'b0, CV, 1'b0});
    check("add_pc", imem_addr, 3);
    tick(1);
    check("halt_enter", halted, 1);
    req_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      req_seen |= dmem_req;
    end
    check("halt_pc", imem_addr, 3);
    check("halt_no_req", req_seen, 0);
    check("halt_hold", {halted, reg_a, reg_b}, {1'b1, 8'h00, 8'hFB});

    // Store A to [0x10], ack after 3 waiting cycles
    clear_rom();
    rom[0] = enc(OP_MOVA_I, 8'h5A);
    rom[1] = enc(OP_STA,    8'h10);
    do_reset();
    tick(2);
    check("st_pre_pc", imem_addr, 1);
    tick(1);
    check("st_mem_first", dmem_req, 0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("st_bus_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, 1'b1, 8'h10, 8'h5A});
      check("st_pc_hold", imem_addr, 1);
      if (i == 3) dmem_ack = 1'b1;
      tick(1);
    end
    dmem_ack = 1'b0;
    check("st_req_drop", dmem_req, 0);
    check("st_pc_adv", imem_addr, 2);
    tick(1);
    check("st_halt", halted, 1);

    // Load B from [0x20] = 7F; SUB/JEQ not taken, then SUB/JEQ taken
    clear_rom();
    rom[0] = enc(OP_MOVA_I, 8'h10);
    rom[1] = enc(OP_LDB,    8'h20);
    rom[2] = enc(OP_SUB,    8'h00);
    rom[3] = enc(OP_JEQ,    8'h08);
    rom[4] = enc(OP_MOVA_I, 8'h7F);
    rom[5] = enc(OP_SUB,    8'h00);
    rom[6] = enc(OP_JEQ,    8'h0A);
    do_reset();
    tick(4);
    check("ld_bus", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 8'h20});
    dmem_rdata = 8'h7F;
    dmem_ack   = 1'b1;
    tick(1);
    dmem_rdata = 8'h00;
    dmem_ack   = 1'b0;
    check("ld_req_drop", dmem_req, 0);
    check("ld_b_before_exec", reg_b, 8'h00);
    tick(1);
    check("ld_b", reg_b, 8'h7F);
    check("ld_pc", imem_addr, 2);
    tick(2);
    check("sub1_a", reg_a, 8'h91);
    check("sub1_flags", flags, {1'b0, 1'b1, CV, 1'b0});
    tick(2);
    check("jeq_not_taken", imem_addr, 4);
    tick(4);
    check("sub2_a", reg_a, 8'h00);
    check("sub2_flags", flags, 4'b1000);
    tick(2);
    check("jeq_taken", imem_addr, 8'h0A);
    tick(1);
    check("ld_halt", halted, 1);

    // Reset asserted mid-MEM with req high
    clear_rom();
    rom[0] = enc(OP_MOVA_I, 8'h80);
    rom[1] = enc(OP_ADD,    8'h00);
    rom[2] = enc(OP_STA,    8'h30);
    do_reset();
    tick(4);
    check("pre_rst_flags", flags, 4'b0100);
    tick(2);
    check("pre_rst_req", dmem_req, 1);
    rst_n    = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check("rst_req_async", dmem_req, 0);
    tick(2);
    dmem_ack = 1'b0;
    rst_n    = 1'b1;
    check("mrst_pc", imem_addr, 0);
    check("mrst_regs", {reg_a, reg_b, flags}, 0);
    tick(2);
    check("mrst_restart", {reg_a, imem_addr}, {8'h80, 8'h01});

    // ADDR_W=4: jump target truncation and PC wrap
    rom4[0]  = enc(OP_JMP, 8'h1A);
    rom4[10] = enc(OP_JMP, 8'h1F);
    rom4[15] = enc(OP_NOP, 8'h00);
    rst4_n = 1'b1;
    tick(2);
    check("a4_jmp_trunc", imem_addr4, 4'hA);
    tick(2);
    check("a4_jmp_f", imem_addr4, 4'hF);
    tick(2);
    check("a4_wrap", imem_addr4, 4'h0);
    check("a4_state", {halted4, dmem_req4}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
